mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding 32-bit word memory target; optional wait states with WAIT_STATES_EN.
// Latency: ready pulses W+1 cycles after acceptance (W = WAIT_CYCLES with WAIT_STATES_EN, else 0).
// Backpressure: none; req is ignored while a transaction is in flight and nothing is queued.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (WAIT_CYCLES < 0) begin : g_bad_wait_cycles
        $error("mem_responder: WAIT_CYCLES must be non-negative");
    end

`ifdef WAIT_STATES_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd2
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        enter_resp;

    logic [31:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [31:0]      acc_addr;
    logic             acc_we;
    logic [31:0]      acc_wdata;
    logic             acc_bad;
    logic [IDX_W-1:0] acc_idx;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic addr_is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    assign accept = (state_q == IDLE) && req;

    // With no wait states the access happens on the acceptance edge itself,
    // so the live inputs must feed the array; otherwise use the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = addr;
            acc_we    = we;
            acc_wdata = wdata;
        end else begin
            acc_addr  = addr_q;
            acc_we    = we_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_bad = addr_is_bad(acc_addr);
    assign acc_idx = acc_addr[IDX_W+1:2];

`ifdef WAIT_STATES_EN
    logic [31:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= 32'(WAIT_CYCLES);
        end else if ((state_q == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
`ifdef WAIT_STATES_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
`else
                    state_d    = RESP;
                    enter_resp = 1'b1;
`endif
                end
            end
`ifdef WAIT_STATES_EN
            WAIT: begin
                if (wait_cnt <= 32'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        rdata = '0;
        if (state_q == RESP) begin
            ready = 1'b1;
            err   = addr_is_bad(addr_q);
            rdata = rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
        end
    end

    // The array has no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && !acc_bad) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (enter_resp && !acc_we && !acc_bad) begin
            rdata_q <= mem[acc_idx];
        end else begin
            rdata_q <= '0;
        end
    end

endmodule
